// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_n
// Brief    : Registered WIDTH-bit ALU with shift-add multiply and tri-state bus output.
// Revision : 1.0
// ============================================================================
module alu_seq_n #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             start,
   input  logic             out_en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] c_op_add = 3'b000;
   localparam logic [2:0] c_op_sub = 3'b001;
   localparam logic [2:0] c_op_adc = 3'b010;
   localparam logic [2:0] c_op_sbb = 3'b011;
   localparam logic [2:0] c_op_and = 3'b100;
   localparam logic [2:0] c_op_or  = 3'b101;
   localparam logic [2:0] c_op_xor = 3'b110;
   localparam logic [2:0] c_op_mul = 3'b111;

   localparam logic [0:0] c_s_idle = 1'b0;
   localparam logic [0:0] c_s_mul  = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplr;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_result_hi;
   logic             r_flag_c;
   logic             r_flag_z;
   logic             r_flag_n;
   logic             r_flag_v;
   logic             r_done;

   logic             w_accept;
   logic             w_last;
   logic             w_busy;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c;
   logic             w_alu_v;
   logic [WIDTH-1:0] w_addend;
   logic [WIDTH:0]   w_macc;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_mplr_nxt;

   assign w_accept = (r_state == c_s_idle) && start;
   assign w_last   = (r_state == c_s_mul) && (r_count == CNT_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_s_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_s_idle: if (w_accept && (op == c_op_mul)) w_state_nxt = c_s_mul;
         c_s_mul:  if (w_last) w_state_nxt = c_s_idle;
         default:  w_state_nxt = c_s_idle;
      endcase
   end

   // FSM outputs
   always_comb begin
      w_busy = (r_state == c_s_mul);
   end

   // Single-cycle ALU; subtraction is A + ~B + carry-in
   always_comb begin
      w_b_eff = ((op == c_op_sub) || (op == c_op_sbb)) ? ~b : b;
      case (op)
         c_op_sub: w_cin = 1'b1;
         c_op_adc: w_cin = r_flag_c;
         c_op_sbb: w_cin = r_flag_c;
         default:  w_cin = 1'b0;
      endcase
      w_sum = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
      w_alu_res = w_sum[WIDTH-1:0];
      w_alu_c   = w_sum[WIDTH];
      w_alu_v   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      case (op)
         c_op_and: begin w_alu_res = a & b; w_alu_c = 1'b0; w_alu_v = 1'b0; end
         c_op_or:  begin w_alu_res = a | b; w_alu_c = 1'b0; w_alu_v = 1'b0; end
         c_op_xor: begin w_alu_res = a ^ b; w_alu_c = 1'b0; w_alu_v = 1'b0; end
         default:  ;
      endcase
   end

   // One shift-add step: the add carry shifts into the accumulator MSB
   always_comb begin
      w_addend   = r_mplr[0] ? r_mcand : {WIDTH{1'b0}};
      w_macc     = {1'b0, r_acc} + {1'b0, w_addend};
      w_acc_nxt  = w_macc[WIDTH:1];
      w_mplr_nxt = {w_macc[0], r_mplr[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand     <= '0;
         r_mplr      <= '0;
         r_acc       <= '0;
         r_count     <= '0;
         r_result    <= '0;
         r_result_hi <= '0;
         r_flag_c    <= 1'b0;
         r_flag_z    <= 1'b0;
         r_flag_n    <= 1'b0;
         r_flag_v    <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept && (op != c_op_mul)) begin
            r_result    <= w_alu_res;
            r_result_hi <= '0;
            r_flag_c    <= w_alu_c;
            r_flag_z    <= (w_alu_res == '0);
            r_flag_n    <= w_alu_res[WIDTH-1];
            r_flag_v    <= w_alu_v;
            r_done      <= 1'b1;
         end else if (w_accept) begin
            r_mcand <= a;
            r_mplr  <= b;
            r_acc   <= '0;
            r_count <= CNT_W'(WIDTH);
         end else if (r_state == c_s_mul) begin
            r_acc   <= w_acc_nxt;
            r_mplr  <= w_mplr_nxt;
            r_count <= r_count - CNT_W'(1);
            if (w_last) begin
               r_result    <= w_mplr_nxt;
               r_result_hi <= w_acc_nxt;
               r_flag_c    <= (w_acc_nxt != '0);
               r_flag_z    <= ({w_acc_nxt, w_mplr_nxt} == '0);
               r_flag_n    <= w_mplr_nxt[WIDTH-1];
               r_flag_v    <= 1'b0;
               r_done      <= 1'b1;
            end
         end
      end
   end

   assign out       = out_en ? r_result : {WIDTH{1'bz}};
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flag_c    = r_flag_c;
   assign flag_z    = r_flag_z;
   assign flag_n    = r_flag_n;
   assign flag_v    = r_flag_v;
   assign busy      = w_busy;
   assign done      = r_done;

endmodule
`default_nettype wire
